grideye_pixel_assembler: RTL and testbench
==========================================

Name: grideye_pixel_assembler

Overview:
- Fabric stage directly downstream of the MSS I2C_1 link to the Grid-EYE (AMG8833) 8x8 thermopile sensor.
- Firmware pushes the 128 raw pixel-register bytes (T01L, T01H … T64L, T64H) into this block one byte at a time.
- The block pairs the bytes into 12-bit signed pixels, stores them in a 64-entry frame RAM and computes per-frame max/min/hotspot index.
- Firmware or a UART formatter reads the results back through a registered read port.

Parameters:
- PIXEL_W, 12, pixel width (two's complement, 0.25 °C/LSB).
- NUM_PIXELS, 64, pixels per frame; index width is 6.
- HOT_THRESH, 12'sd148, hot-pixel threshold (37.0 °C); used only with the optional feature.

Ports:
- FAB_CLK  in  1  fabric clock.
- M2F_RESET_N  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse; begins a new frame.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  raw register byte from the I2C read.
- byte_ready  out  1  block accepts the byte this cycle.
- frame_done  out  1  single-cycle pulse after the 64th pixel is written.
- frame_abort  out  1  single-cycle pulse when frame_start interrupts a partial frame.
- frame_valid  out  1  RAM holds a complete, unmodified frame.
- max_val  out  12  signed maximum pixel of the last completed frame.
- min_val  out  12  signed minimum pixel of the last completed frame.
- max_idx  out  6  index of max_val (first occurrence).
- rd_addr  in  6  readback address.
- rd_data  out  12  pixel at rd_addr, registered.

Behaviour:
- Reset values:
  - state=IDLE, byte_ready=1, pulses=0, frame_valid=0, max_val=min_val=0, max_idx=0, rd_data=0, pixel index=0.
  - RAM contents are undefined after reset.
- Reset may assert at any time, including mid-frame. All state clears; no frame_done or frame_abort pulse is issued.
- Handshake: a byte transfers when byte_valid && byte_ready. byte_ready is 1 in every state except DONE.
- States:
  - IDLE: accepted bytes are discarded. frame_start -> LO, idx=0, frame_valid cleared, running max/min seeded from the first pixel.
  - LO: accepted byte is latched as the low byte -> HI.
  - HI: accepted byte supplies bits [11:8] from byte_data[3:0]; bits [7:4] are ignored. The pixel is written to RAM[idx] in the same cycle, and running stats update. If idx==63 -> DONE, else idx++ and -> LO.
  - DONE (one cycle): frame_done=1, frame_valid=1; max_val/min_val/max_idx are loaded from the running registers; -> IDLE.
- Stats:
  - Signed compare on 12 bits.
  - Max uses strict >, so ties keep the lowest index. Min uses strict <.
  - Pixel 0 initialises both running max and running min.
- frame_start in LO or HI (partial frame): frame_abort pulses, idx=0, -> LO. Published stats and RAM words are not cleared; frame_valid stays 0.
- frame_start in DONE: honoured on the following IDLE cycle only if it is reasserted. A pulse that lands in DONE is dropped.
- frame_start and an accepted byte in the same cycle: frame_start wins and the byte is discarded.
- Read port: rd_data = RAM[rd_addr] with 1-cycle latency. A read and a write to the same address in the same cycle return the old data.

Optional Feature:
- Macro GRIDEYE_HOT_COUNT_EN.
- Defined:
  - Adds output hot_count (7 bits, range 0..64): the number of pixels in the last completed frame with value > HOT_THRESH (signed).
  - The running counter clears at frame_start and publishes with frame_done.
  - hot_count resets to 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package grideye_pkg holds:
  - PIXEL_W, NUM_PIXELS, IDX_W=6, default HOT_THRESH.
  - State enum {IDLE, LO, HI, DONE}.
  - Function pixel_from_bytes(lo, hi) returning the 12-bit signed pixel.
- Sub-module grideye_frame_ram: 64x12 single-write, single-read synchronous RAM with registered read, mapped to fabric RAM.

Test Plan:
- Reset, then frame_start, then 128 bytes encoding pixel i = i*4 (lo=(i*4)&FF, hi=(i*4)>>8) -> frame_done exactly one cycle after byte 128 is accepted; max_val=252, max_idx=63, min_val=0; rd_addr=10 gives rd_data=40 one cycle later.
- Frame where pixel 5 = 0xF00 (-256), pixel 20 = pixel 40 = 0x190 (400), all others 0x064 -> min_val=-256, max_val=400, max_idx=20.
- High bytes with garbage upper nibble 0xA_ (e.g. hi=0xA1, lo=0x2C) -> pixel=0x12C (300); bits [7:4] have no effect.
- frame_start after 37 bytes -> frame_abort pulse, frame_valid=0; the next full 128-byte frame completes normally with correct stats.
- Assert M2F_RESET_N low mid-HI state -> all outputs return to reset values immediately; bytes without a frame_start are consumed (byte_ready=1) and have no effect.
- With GRIDEYE_HOT_COUNT_EN: frame with 3 pixels at 149 and one at 148 -> hot_count=3.

Source files
------------

// File: rtl/grideye_pkg.sv
// grideye_pkg: shared widths, FSM states and byte-pair decode for the Grid-EYE pixel assembler.
package grideye_pkg;
    localparam int PIXEL_W    = 12;
    localparam int NUM_PIXELS = 64;
    localparam int IDX_W      = 6;
    localparam logic signed [PIXEL_W-1:0] HOT_THRESH = 12'sd148;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    // Upper nibble of the high register byte carries no pixel data.
    function automatic logic signed [PIXEL_W-1:0] pixel_from_bytes(input logic [7:0] lo, input logic [7:0] hi);
        return $signed({hi[3:0], lo});
    endfunction
endpackage

// File: rtl/grideye_frame_ram.sv
// grideye_frame_ram: 64x12 frame store, one write port and one registered read port (read-before-write).
module grideye_frame_ram
    import grideye_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [PIXEL_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [PIXEL_W-1:0] rdata_o
);
    logic [PIXEL_W-1:0] mem [NUM_PIXELS];
    logic [PIXEL_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/grideye_pixel_assembler.sv
// grideye_pixel_assembler: pairs raw AMG8833 bytes into 12-bit pixels, stores a frame and tracks max/min.
// Optional GRIDEYE_HOT_COUNT_EN adds hot_count (pixels above HOT_THRESH in the last frame).
module grideye_pixel_assembler
    import grideye_pkg::*;
(
    input  logic                      FAB_CLK,
    input  logic                      M2F_RESET_N,
    input  logic                      frame_start,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      byte_ready,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      frame_valid,
    output logic signed [PIXEL_W-1:0] max_val,
    output logic signed [PIXEL_W-1:0] min_val,
    output logic [IDX_W-1:0]          max_idx,
    input  logic [IDX_W-1:0]          rd_addr,
    output logic [PIXEL_W-1:0]        rd_data
`ifdef GRIDEYE_HOT_COUNT_EN
    ,
    output logic [6:0]                hot_count
`endif
);
    state_e                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [7:0]                lo_q;
    logic signed [PIXEL_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d, pix;
    logic [IDX_W-1:0]          run_idx_q, run_idx_d;
    logic signed [PIXEL_W-1:0] max_q, min_q;
    logic [IDX_W-1:0]          max_idx_q;
    logic                      done_q, abort_q, valid_q;
    logic                      accept, wr_en, first, last, new_max;

    assign byte_ready = state_q != DONE;
    // frame_start outranks a simultaneous byte, so the byte is dropped
    assign accept     = byte_valid && byte_ready && !frame_start;
    assign wr_en      = accept && state_q == HI;
    assign pix        = pixel_from_bytes(lo_q, byte_data);
    assign first      = idx_q == '0;
    assign last       = idx_q == IDX_W'(NUM_PIXELS - 1);
    assign new_max    = first || pix > run_max_q;
    assign run_max_d  = new_max ? pix : run_max_q;
    assign run_idx_d  = new_max ? idx_q : run_idx_q;
    assign run_min_d  = (first || pix < run_min_q) ? pix : run_min_q;

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            lo_q      <= '0;
            run_max_q <= '0;
            run_min_q <= '0;
            run_idx_q <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: if (frame_start) begin
                    state_q <= LO;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end
                LO, HI: if (frame_start) begin
                    abort_q <= 1'b1;
                    idx_q   <= '0;
                    state_q <= LO;
                end else if (accept && state_q == LO) begin
                    lo_q    <= byte_data;
                    state_q <= HI;
                end else if (accept) begin
                    run_max_q <= run_max_d;
                    run_min_q <= run_min_d;
                    run_idx_q <= run_idx_d;
                    if (last) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        max_q     <= run_max_d;
                        min_q     <= run_min_d;
                        max_idx_q <= run_idx_d;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= LO;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GRIDEYE_HOT_COUNT_EN
    logic [6:0] run_hot_q, run_hot_d, hot_q;
    assign run_hot_d = run_hot_q + 7'(pix > HOT_THRESH);

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            run_hot_q <= '0;
            hot_q     <= '0;
        end else if (frame_start && state_q != DONE) begin
            run_hot_q <= '0;
        end else if (wr_en) begin
            run_hot_q <= run_hot_d;
            if (last) hot_q <= run_hot_d;
        end
    end

    assign hot_count = hot_q;
`endif

    grideye_frame_ram u_ram (
        .clk_i   (FAB_CLK),
        .rst_ni  (M2F_RESET_N),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (pix),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_valid = valid_q;
    assign max_val     = max_q;
    assign min_val     = min_q;
    assign max_idx     = max_idx_q;
endmodule

// File: tb/tb_grideye_pixel_assembler.sv
// tb_grideye_pixel_assembler: directed checks of framing, stats, abort, reset and readback.
module tb_grideye_pixel_assembler;
    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic [5:0]  rd_addr = '0;
    logic        byte_ready, frame_done, frame_abort, frame_valid;
    logic [11:0] max_val, min_val, rd_data;
    logic [5:0]  max_idx;
`ifdef GRIDEYE_HOT_COUNT_EN
    logic [6:0]  hot_count;
`endif
    int          tests = 0, fails = 0;
    logic [11:0] px [64];

    always #5 clk = ~clk;

    grideye_pixel_assembler dut (
        .FAB_CLK     (clk),
        .M2F_RESET_N (rst_n),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_valid (frame_valid),
        .max_val     (max_val),
        .min_val     (min_val),
        .max_idx     (max_idx),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef GRIDEYE_HOT_COUNT_EN
        ,
        .hot_count   (hot_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] junk);
        for (int i = 0; i < 64; i++) begin
            send_byte(px[i][7:0]);
            send_byte({junk, px[i][11:8]});
        end
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [11:0] exp, input string tag);
        rd_addr = a;
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #12;
        chk("rst_ready", byte_ready, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_max", max_val, 0);
        chk("rst_min", min_val, 0);
        chk("rst_idx", max_idx, 0);
        chk("rst_rd", rd_data, 0);
`ifdef GRIDEYE_HOT_COUNT_EN
        chk("rst_hot", hot_count, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Ramp frame: pixel i = 4*i
        for (int i = 0; i < 64; i++) px[i] = 12'(i * 4);
        start();
        chk("f1_valid_clr", frame_valid, 0);
        send_frame(4'h0);
        chk("f1_done", frame_done, 1);
        chk("f1_ready_low", byte_ready, 0);
        chk("f1_valid", frame_valid, 1);
        chk("f1_max", max_val, 12'd252);
        chk("f1_min", min_val, 12'd0);
        chk("f1_idx", max_idx, 6'd63);
        tick();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_ready_back", byte_ready, 1);
        rd(6'd10, 12'd40, "f1_rd10");
        rd(6'd63, 12'd252, "f1_rd63");

        // Negative min, tied max, start dropped in DONE, IDLE bytes ignored
        for (int i = 0; i < 64; i++) px[i] = 12'h064;
        px[5] = 12'hF00; px[20] = 12'h190; px[40] = 12'h190;
        start();
        send_frame(4'h0);
        chk("f2_done", frame_done, 1);
        start();
        send_byte(8'h55);
        send_byte(8'h07);
        chk("f2_max", max_val, 12'h190);
        chk("f2_min", min_val, 12'hF00);
        chk("f2_idx", max_idx, 6'd20);
        chk("f2_valid_kept", frame_valid, 1);
        chk("f2_no_done", frame_done, 0);
        rd(6'd0, 12'h064, "f2_rd0");
        rd(6'd5, 12'hF00, "f2_rd5");
        rd(6'd40, 12'h190, "f2_rd40");

        // Garbage upper nibble on every high byte
        for (int i = 0; i < 64; i++) px[i] = 12'h000;
        px[0] = 12'h12C;
        start();
        send_frame(4'hA);
        chk("f3_max", max_val, 12'h12C);
        chk("f3_idx", max_idx, 6'd0);
        chk("f3_min", min_val, 12'h000);
        rd(6'd0, 12'h12C, "f3_rd0");
        rd(6'd1, 12'h000, "f3_rd1");

        // Abort after 37 bytes, with a byte colliding with the restart
        start();
        for (int i = 0; i < 18; i++) begin
            send_byte(8'hFF);
            send_byte(8'h07);
        end
        send_byte(8'hFF);
        frame_start = 1'b1;
        byte_valid  = 1'b1;
        byte_data   = 8'h99;
        tick();
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        chk("ab_pulse", frame_abort, 1);
        chk("ab_valid", frame_valid, 0);
        chk("ab_max_kept", max_val, 12'h12C);
        tick();
        chk("ab_pulse_end", frame_abort, 0);
        for (int i = 0; i < 64; i++) px[i] = (i == 33) ? 12'd500 : 12'(i * 2 - 50);
        send_frame(4'h0);
        chk("f4_done", frame_done, 1);
        chk("f4_valid", frame_valid, 1);
        chk("f4_max", max_val, 12'h1F4);
        chk("f4_idx", max_idx, 6'd33);
        chk("f4_min", min_val, 12'hFCE);
        tick();
        rd(6'd18, 12'hFF2, "f4_rd18");
        rd(6'd33, 12'h1F4, "f4_rd33");

        // Reset while in HI
        start();
        send_byte(8'h11);
        send_byte(8'h02);
        send_byte(8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ready", byte_ready, 1);
        chk("mr_valid", frame_valid, 0);
        chk("mr_max", max_val, 0);
        chk("mr_min", min_val, 0);
        chk("mr_idx", max_idx, 0);
        chk("mr_rd", rd_data, 0);
        chk("mr_done", frame_done, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h44);
        chk("mr_after_ready", byte_ready, 1);
        chk("mr_after_done", frame_done, 0);
        chk("mr_after_valid", frame_valid, 0);
        chk("mr_after_max", max_val, 0);

`ifdef GRIDEYE_HOT_COUNT_EN
        for (int i = 0; i < 64; i++) px[i] = 12'h000;
        px[0] = 12'd149; px[1] = 12'd149; px[2] = 12'd149; px[3] = 12'd148;
        start();
        send_frame(4'h0);
        chk("hot_count", hot_count, 7'd3);
        chk("hot_max", max_val, 12'd149);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
